ram_access_arbiter: RTL and testbench
=====================================

# ram_access_arbiter

Round-robin arbiter that shares the separate write and read ports of a dual-port RAM between N requesters. Each requester issues single-beat read or write requests over a valid/ready handshake; the arbiter grants at most one write and one read per cycle, drives the RAM ports, and routes the registered read data back to the requester that issued the read. It sits directly in front of the RAM on a single clock domain, with the RAM's write and read clocks tied to the same clock.

## Interface
- WIDTH, 8, data word width in bits
- DEPTH, 16, number of RAM words
- ADDRESS_WIDTH, `CLOG2(DEPTH), address width
- REQUESTERS, 2, number of requesters (N ≥ 2)

Ports:
- clock  input  1  single clock for the arbiter and the RAM
- reset  input  1  synchronous, active-high reset
- request_valid  input  N  per-requester request valid
- request_write  input  N  per-requester direction: 1 = write, 0 = read
- request_address  input  N×ADDRESS_WIDTH  flattened addresses, requester i at bits [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- request_data  input  N×WIDTH  flattened write data
- request_ready  output  N  per-requester accept, combinational
- response_valid  output  N  one-hot read-response strobe
- response_data  output  WIDTH  read data shared by all requesters
- memory_write_enable  output  1  to RAM write_enable
- memory_write_address  output  ADDRESS_WIDTH  to RAM write_address
- memory_write_data  output  WIDTH  to RAM write_data
- memory_read_enable  output  1  to RAM read_enable
- memory_read_address  output  ADDRESS_WIDTH  to RAM read_address
- memory_read_data  input  WIDTH  from RAM read_data, valid the cycle after memory_read_enable

## Operation
- Two independent arbitration classes: write (valid & write) and read (valid & !write). Each class has its own round-robin pointer, log2(N) bits.
- Within a class, scan from the pointer upward modulo N. The first valid requester is granted: request_ready[i]=1 and its address/data drive the RAM port with the enable high.
- Pointer update on a grant to i: pointer ← (i+1) mod N. There is no update without a grant.
- A transfer occurs when valid & ready. request_ready never depends on ready; valid must be held until ready. Address, data and direction must be stable while waiting.
- Fairness bound: a requester holding valid is granted within N cycles in its class.
- Read tracking: a registered one-hot response_valid ← read grant vector. response_data = memory_read_data.
- Unselected memory address/data outputs: 0 when the enable is low.
- Reset (reset=1 at a clock edge): both pointers ← 0, response_valid ← 0. While reset is high, request_ready=0 and both memory enables are 0. A read granted the cycle before reset asserts produces no response. RAM contents are not cleared by this block.

## Timing
- Write: accepted in cycle T; RAM updated at the T→T+1 edge. No response.
- Read: accepted in cycle T; response_valid[i]=1 and data on response_data in cycle T+1, exactly one cycle.
- Back-to-back reads from the same or different requesters are accepted every cycle, and responses follow in order, one per cycle.
- Simultaneous write and read to the same address in cycle T: behaviour depends on the bypass configuration.
- Combinational path: request_valid → request_ready / memory_* outputs, no pipeline stage.

## Configuration
- RAM_ACCESS_ARBITER_BYPASS_EN defined: on a same-cycle write and read to the same address, the arbiter registers a bypass flag and the write data. In T+1, response_data = the registered write data, so the read returns the new value.
- Not defined: no bypass logic. A same-address collision returns the old RAM contents, and response_data is always memory_read_data.

## Test plan
- Reset then idle: hold reset 3 cycles with all valids high → request_ready=0, enables=0, response_valid=0. After release, both pointers start at 0 and requester 0 wins first.
- Round-robin: N=2, both requesters continuously write addr 1/2 → grants alternate 0,1,0,1. Each is granted within 2 cycles.
- Concurrent classes: requester 0 writes 0xA5 to addr 3 while requester 1 reads addr 7 (preloaded 0x3C) in the same cycle → both ready=1. Next cycle response_valid=2'b10, response_data=0x3C.
- Collision: addr 4 holds 0x11; same cycle, requester 0 writes 0x22 to addr 4 and requester 1 reads addr 4 → response 0x22 with bypass, 0x11 without.
- Reset mid-read: read of addr 5 accepted in cycle T with reset high at the T+1 edge → response_valid stays 0. After release, pointers are at 0.
- Read streaming: requester 1 reads addr 0..15 back-to-back, 16 cycles → 16 consecutive responses in order, one per cycle, with no gaps.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing the write and read ports of a dual-port RAM among N requesters.
// Optional same-address write-to-read bypass is enabled by defining RAM_ACCESS_ARBITER_BYPASS_EN.
module ram_access_arbiter #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 16,
   parameter int ADDRESS_WIDTH = $clog2(DEPTH),
   parameter int REQUESTERS    = 2
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [REQUESTERS-1:0]              request_valid,
   input  logic [REQUESTERS-1:0]              request_write,
   input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] request_address,
   input  logic [REQUESTERS*WIDTH-1:0]        request_data,
   output logic [REQUESTERS-1:0]              request_ready,
   output logic [REQUESTERS-1:0]              response_valid,
   output logic [WIDTH-1:0]                   response_data,
   output logic                               memory_write_enable,
   output logic [ADDRESS_WIDTH-1:0]           memory_write_address,
   output logic [WIDTH-1:0]                   memory_write_data,
   output logic                               memory_read_enable,
   output logic [ADDRESS_WIDTH-1:0]           memory_read_address,
   input  logic [WIDTH-1:0]                   memory_read_data
);

   localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   logic [PW-1:0]         write_ptr_q, write_ptr_d;
   logic [PW-1:0]         read_ptr_q, read_ptr_d;
   logic [REQUESTERS-1:0] response_valid_q;
   logic [REQUESTERS-1:0] write_gnt_s, read_gnt_s;

   // Requests at or above the pointer win first; otherwise wrap to the lowest index.
   function automatic logic [REQUESTERS-1:0] rr_pick(input logic [REQUESTERS-1:0] req,
                                                     input logic [PW-1:0] ptr);
      logic [REQUESTERS-1:0] mask;
      logic [REQUESTERS-1:0] masked;
      logic [REQUESTERS-1:0] pick;
      mask = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      masked = req & mask;
      if (masked != '0) begin
         pick = masked & (~masked + REQUESTERS'(1));
      end else begin
         pick = req & (~req + REQUESTERS'(1));
      end
      return pick;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [REQUESTERS-1:0] gnt);
      logic [PW-1:0] nxt;
      nxt = '0;
      for (int i = 0; i < REQUESTERS; i++) begin
         if (gnt[i]) begin
            nxt = (i == REQUESTERS - 1) ? PW'(0) : PW'(i + 1);
         end
      end
      return nxt;
   endfunction

   always_comb begin
      write_gnt_s          = '0;
      read_gnt_s           = '0;
      memory_write_address = '0;
      memory_write_data    = '0;
      memory_read_address  = '0;
      if (reset) begin
         write_gnt_s = '0;
         read_gnt_s  = '0;
      end else begin
         write_gnt_s = rr_pick(request_valid & request_write, write_ptr_q);
         read_gnt_s  = rr_pick(request_valid & ~request_write, read_ptr_q);
      end
      for (int i = 0; i < REQUESTERS; i++) begin
         if (write_gnt_s[i]) begin
            memory_write_address = request_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            memory_write_data    = request_data[i*WIDTH +: WIDTH];
         end
         if (read_gnt_s[i]) begin
            memory_read_address = request_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         end
      end
      write_ptr_d = (write_gnt_s != '0) ? next_ptr(write_gnt_s) : write_ptr_q;
      read_ptr_d  = (read_gnt_s != '0) ? next_ptr(read_gnt_s) : read_ptr_q;
   end

   assign request_ready       = write_gnt_s | read_gnt_s;
   assign memory_write_enable = |write_gnt_s;
   assign memory_read_enable  = |read_gnt_s;
   // A response pending across a reset edge is suppressed while reset is still high.
   assign response_valid      = reset ? '0 : response_valid_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         write_ptr_q      <= '0;
         read_ptr_q       <= '0;
         response_valid_q <= '0;
      end else begin
         write_ptr_q      <= write_ptr_d;
         read_ptr_q       <= read_ptr_d;
         response_valid_q <= read_gnt_s;
      end
   end

`ifdef RAM_ACCESS_ARBITER_BYPASS_EN
   logic             bypass_q, bypass_d;
   logic [WIDTH-1:0] bypass_data_q;

   assign bypass_d = memory_write_enable & memory_read_enable &
                     (memory_write_address == memory_read_address);

   always_ff @(posedge clock) begin
      if (reset) begin
         bypass_q      <= 1'b0;
         bypass_data_q <= '0;
      end else begin
         bypass_q      <= bypass_d;
         bypass_data_q <= memory_write_data;
      end
   end

   assign response_data = bypass_q ? bypass_data_q : memory_read_data;
`else
   assign response_data = memory_read_data;
`endif

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: vector table, hand sequences, then random traffic
// against a queue/array reference model. A behavioural RAM sits behind the arbiter.
module tb_ram_access_arbiter;

   typedef struct {
      logic       rst;
      logic [1:0] v, w;
      logic [3:0] a0, a1;
      logic [7:0] d0, d1;
      logic [1:0] rdy;
      logic       we;
      logic [3:0] wa;
      logic [7:0] wd;
      logic       re;
      logic [3:0] ra;
      logic [1:0] rv;
      logic       crd;
      logic [7:0] rd;
   } vec_t;

`ifdef RAM_ACCESS_ARBITER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] request_valid, request_write, request_ready, response_valid;
   logic [7:0] request_address;
   logic [15:0] request_data;
   logic [7:0] response_data;
   logic       memory_write_enable, memory_read_enable;
   logic [3:0] memory_write_address, memory_read_address;
   logic [7:0] memory_write_data, memory_read_data;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic load = 1'b0;
   logic [7:0] ram [16];
   logic [7:0] exp_mem [16];

   ram_access_arbiter dut (
      .clock(clock), .reset(reset),
      .request_valid(request_valid), .request_write(request_write),
      .request_address(request_address), .request_data(request_data),
      .request_ready(request_ready), .response_valid(response_valid),
      .response_data(response_data),
      .memory_write_enable(memory_write_enable), .memory_write_address(memory_write_address),
      .memory_write_data(memory_write_data), .memory_read_enable(memory_read_enable),
      .memory_read_address(memory_read_address), .memory_read_data(memory_read_data)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] init_val(input int a);
      if (a == 4) return 8'h11;
      if (a == 7) return 8'h3C;
      return 8'h50 + 8'(a);
   endfunction

   always @(posedge clock) begin
      if (load) begin
         for (int i = 0; i < 16; i++) ram[i] <= init_val(i);
      end else begin
         if (memory_write_enable) ram[memory_write_address] <= memory_write_data;
      end
      if (memory_read_enable) memory_read_data <= ram[memory_read_address];
   end

   function automatic vec_t mk(input logic rst, input logic [1:0] v, input logic [1:0] w,
                               input logic [3:0] a0, input logic [3:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [1:0] rdy, input logic we, input logic [3:0] wa,
                               input logic [7:0] wd, input logic re, input logic [3:0] ra,
                               input logic [1:0] rv, input logic crd, input logic [7:0] rd);
      vec_t t;
      t.rst = rst; t.v = v; t.w = w; t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
      t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd; t.re = re; t.ra = ra;
      t.rv = rv; t.crd = crd; t.rd = rd;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check outputs mid-cycle, then advance past the next edge.
   task automatic step(input vec_t t);
      reset           = t.rst;
      request_valid   = t.v;
      request_write   = t.w;
      request_address = {t.a1, t.a0};
      request_data    = {t.d1, t.d0};
      #2;
      chk("request_ready", 32'(request_ready), 32'(t.rdy));
      chk("write_enable", 32'(memory_write_enable), 32'(t.we));
      chk("write_address", 32'(memory_write_address), 32'(t.wa));
      chk("write_data", 32'(memory_write_data), 32'(t.wd));
      chk("read_enable", 32'(memory_read_enable), 32'(t.re));
      chk("read_address", 32'(memory_read_address), 32'(t.ra));
      chk("response_valid", 32'(response_valid), 32'(t.rv));
      if (t.crd) chk("response_data", 32'(response_data), 32'(t.rd));
      @(posedge clock);
      #1;
      cyc++;
   endtask

   vec_t tbl [16];
   vec_t t;

   // random-phase model state
   int pw, pr, gw, gr, pend_i;
   logic pend_v;
   logic [7:0] pend_d;
   logic [1:0] cv, cw;
   logic [3:0] ca [2];
   logic [7:0] cd [2];
   logic rst_r;

   initial begin
      for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
      reset = 1'b1; load = 1'b1;
      request_valid = 2'b00; request_write = 2'b00; request_address = 8'h00; request_data = 16'h0000;
      @(posedge clock);
      #1;
      load = 1'b0;

      for (int i = 0; i < 3; i++)
         tbl[i] = mk(1'b1, 2'b11, 2'b01, 4'd1, 4'd2, 8'hAA, 8'hBB,
                     2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 2'b00, 1'b0, 8'h00);
      tbl[3]  = mk(1'b0, 2'b11, 2'b11, 4'd1, 4'd2, 8'hAA, 8'hBB, 2'b01, 1'b1, 4'd1, 8'hAA, 1'b0, 4'd0, 2'b00, 1'b0, 8'h00);
      tbl[4]  = mk(1'b0, 2'b11, 2'b11, 4'd1, 4'd2, 8'hAA, 8'hBB, 2'b10, 1'b1, 4'd2, 8'hBB, 1'b0, 4'd0, 2'b00, 1'b0, 8'h00);
      tbl[5]  = mk(1'b0, 2'b11, 2'b11, 4'd1, 4'd2, 8'hAA, 8'hBB, 2'b01, 1'b1, 4'd1, 8'hAA, 1'b0, 4'd0, 2'b00, 1'b0, 8'h00);
      tbl[6]  = mk(1'b0, 2'b11, 2'b11, 4'd1, 4'd2, 8'hAA, 8'hBB, 2'b10, 1'b1, 4'd2, 8'hBB, 1'b0, 4'd0, 2'b00, 1'b0, 8'h00);
      tbl[7]  = mk(1'b0, 2'b11, 2'b01, 4'd3, 4'd7, 8'hA5, 8'h00, 2'b11, 1'b1, 4'd3, 8'hA5, 1'b1, 4'd7, 2'b00, 1'b0, 8'h00);
      tbl[8]  = mk(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 2'b10, 1'b1, 8'h3C);
      tbl[9]  = mk(1'b0, 2'b11, 2'b01, 4'd4, 4'd4, 8'h22, 8'h00, 2'b11, 1'b1, 4'd4, 8'h22, 1'b1, 4'd4, 2'b00, 1'b0, 8'h00);
      tbl[10] = mk(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 2'b10, 1'b1,
                   BYP ? 8'h22 : 8'h11);
      tbl[11] = mk(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 2'b00, 1'b0, 8'h00);
      tbl[12] = mk(1'b0, 2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 2'b00, 1'b0, 8'h00);
      tbl[13] = mk(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 2'b01, 1'b1, 8'hA5);
      tbl[14] = mk(1'b0, 2'b10, 2'b00, 4'd0, 4'd1, 8'h00, 8'h00, 2'b10, 1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 2'b00, 1'b0, 8'h00);
      tbl[15] = mk(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 2'b10, 1'b1, 8'hAA);

      for (int i = 0; i < 16; i++) begin
         step(tbl[i]);
         if (!tbl[i].rst && tbl[i].we) exp_mem[tbl[i].wa] = tbl[i].wd;
      end

      // read accepted, then reset arrives: no response, both pointers back at 0
      step(mk(1'b0, 2'b10, 2'b00, 4'd0, 4'd5, 8'h00, 8'h00, 2'b10, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 2'b00, 1'b0, 8'h00));
      step(mk(1'b1, 2'b11, 2'b00, 4'd6, 4'd5, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 2'b00, 1'b0, 8'h00));
      step(mk(1'b0, 2'b11, 2'b00, 4'd6, 4'd5, 8'h00, 8'h00, 2'b01, 1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 2'b00, 1'b0, 8'h00));
      step(mk(1'b0, 2'b11, 2'b11, 4'd8, 4'd9, 8'h77, 8'h88, 2'b01, 1'b1, 4'd8, 8'h77, 1'b0, 4'd0, 2'b01, 1'b1, exp_mem[6]));
      exp_mem[8] = 8'h77;

      // back-to-back streaming reads of every address by requester 1
      for (int k = 0; k < 16; k++) begin
         t = mk(1'b0, 2'b10, 2'b00, 4'd0, 4'(k), 8'h00, 8'h00, 2'b10, 1'b0, 4'd0, 8'h00, 1'b1, 4'(k),
                (k == 0) ? 2'b00 : 2'b10, (k != 0), (k == 0) ? 8'h00 : exp_mem[k-1]);
         step(t);
      end
      step(mk(1'b0, 2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 2'b10, 1'b1, exp_mem[15]));

      // random traffic against the reference model
      pw = 0; pr = 0; pend_v = 1'b0; pend_i = 0; pend_d = 8'h00; cv = 2'b00; cw = 2'b00;
      for (int i = 0; i < 2; i++) begin ca[i] = 4'd0; cd[i] = 8'h00; end
      for (int n = 0; n < 2000; n++) begin
         rst_r = (n == 0) || ($urandom_range(0, 39) == 0);
         for (int i = 0; i < 2; i++) begin
            if (!cv[i] && $urandom_range(0, 99) < 65) begin
               cv[i] = 1'b1;
               cw[i] = 1'($urandom_range(0, 1));
               ca[i] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
               cd[i] = 8'($urandom_range(0, 255));
            end
         end
         gw = -1; gr = -1;
         if (!rst_r) begin
            for (int k = 0; k < 2; k++) begin
               if (gw < 0 && cv[(pw + k) % 2] && cw[(pw + k) % 2]) gw = (pw + k) % 2;
               if (gr < 0 && cv[(pr + k) % 2] && !cw[(pr + k) % 2]) gr = (pr + k) % 2;
            end
         end
         t = mk(rst_r, cv, cw, ca[0], ca[1], cd[0], cd[1], 2'b00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0,
                2'b00, 1'b0, 8'h00);
         if (gw >= 0) begin t.rdy[gw] = 1'b1; t.we = 1'b1; t.wa = ca[gw]; t.wd = cd[gw]; end
         if (gr >= 0) begin t.rdy[gr] = 1'b1; t.re = 1'b1; t.ra = ca[gr]; end
         if (!rst_r && pend_v) begin t.rv[pend_i] = 1'b1; t.crd = 1'b1; t.rd = pend_d; end
         step(t);
         if (rst_r) begin
            pw = 0; pr = 0; pend_v = 1'b0;
         end else begin
            pend_v = (gr >= 0);
            if (gr >= 0) begin
               pend_i = gr;
               pend_d = (BYP && gw >= 0 && ca[gw] == ca[gr]) ? cd[gw] : exp_mem[ca[gr]];
               pr = (gr + 1) % 2;
               cv[gr] = 1'b0;
            end
            if (gw >= 0) begin
               exp_mem[ca[gw]] = cd[gw];
               pw = (gw + 1) % 2;
               cv[gw] = 1'b0;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
